// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: widths, grant source
// encoding and the MDU result buffer entry.
package rf_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MDU  = 2'd2
    } gnt_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the EX/WB/decode stages (master) and the write-port
// arbiter (slave), including the register file write port it drives.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;
    logic              mdu_issue;
    logic [REG_AW-1:0] mdu_issue_rd;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_AW-1:0] mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_hazard;
    logic              rf_wr;
    logic [REG_AW-1:0] rf_a3;
    logic [DATA_W-1:0] rf_wd;

    modport master (
        output wb_valid, wb_rd, wb_data, mdu_issue, mdu_issue_rd,
               mdu_valid, mdu_rd, mdu_data, id_rs, id_rt,
        input  wb_stall, mdu_ready, id_hazard, rf_wr, rf_a3, rf_wd
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, mdu_issue, mdu_issue_rd,
               mdu_valid, mdu_rd, mdu_data, id_rs, id_rt,
        output wb_stall, mdu_ready, id_hazard, rf_wr, rf_a3, rf_wd
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// MDU result buffer: DEPTH-entry FIFO of {rd, data} with registered count,
// full and empty flags. Head entry is visible on rdata while non-empty.
module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  buf_entry_t             wdata,
    input  logic                   pop,
    output buf_entry_t             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    buf_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between WB and the buffered MDU results,
// with starvation bound and RAW scoreboard. Optional trace: RF_WB_TRACE_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           rst,
    rf_wb_arbiter_if.slave bus
);

    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    buf_entry_t        head;
    buf_entry_t        push_entry;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    gnt_src_e          gnt;
    logic              stall;
    logic              wr;
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [3:0]        wait_q;
    logic [3:0]        wait_d;
    logic [31:0]       sb_q;
    logic [31:0]       sb_d;

    // rd=0 results are acknowledged but never stored.
    assign push       = bus.mdu_valid && !fifo_full && (bus.mdu_rd != '0);
    assign push_entry = '{rd: bus.mdu_rd, data: bus.mdu_data};
    assign pop        = (gnt == GNT_MDU);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        gnt   = GNT_NONE;
        stall = 1'b0;
        if (!fifo_empty && (wait_q == WAIT_MAX)) begin
            gnt   = GNT_MDU;
            stall = bus.wb_valid;
        end else if (bus.wb_valid) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_MDU;
        end
    end

    always_comb begin
        wr = 1'b0;
        a3 = '0;
        wd = '0;
        case (gnt)
            GNT_WB: begin
                if (bus.wb_rd != '0) begin
                    wr = 1'b1;
                    a3 = bus.wb_rd;
                    wd = bus.wb_data;
                end
            end
            GNT_MDU: begin
                wr = 1'b1;
                a3 = head.rd;
                wd = head.data;
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop)
            wait_d = '0;
        else if (wait_q != WAIT_MAX)
            wait_d = wait_q + 4'd1;
    end

    // A new issue to the same rd outranks the retiring result.
    always_comb begin
        sb_d = sb_q;
        if (pop)           sb_d[head.rd]          = 1'b0;
        if (bus.mdu_issue) sb_d[bus.mdu_issue_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            sb_q   <= '0;
        end else begin
            wait_q <= wait_d;
            sb_q   <= sb_d;
        end
    end

    assign bus.wb_stall  = stall;
    assign bus.mdu_ready = !fifo_full;
    assign bus.id_hazard = ((bus.id_rs != '0) && sb_q[bus.id_rs]) ||
                           ((bus.id_rt != '0) && sb_q[bus.id_rt]);
    assign bus.rf_wr     = wr;
    assign bus.rf_a3     = a3;
    assign bus.rf_wd     = wd;

`ifdef RF_WB_TRACE_EN
    always @(posedge clk) begin
        if (!rst && wr)
            $display("wb[%s] r[%02d] = 0x%08h", (gnt == GNT_WB) ? "WB" : "MDU", a3, wd);
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.mdu_issue = 0; bus.mdu_issue_rd = 0;
        bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
        bus.id_rs = 0; bus.id_rt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL reset_mdu_ready got=%b exp=1", bus.mdu_ready); end
        checks++; if (bus.wb_stall !== 1'b0) begin failures++; $display("FAIL reset_wb_stall got=%b exp=0", bus.wb_stall); end
        checks++; if (bus.id_hazard !== 1'b0) begin failures++; $display("FAIL reset_id_hazard got=%b exp=0", bus.id_hazard); end
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== 38'd0) begin failures++; $display("FAIL reset_rf_port got=%b/%0d/%h exp=0/0/0", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wb_only();
        bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h1234;
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd5, 32'h1234}) begin failures++; $display("FAIL wb_only_write got=%b/%0d/%h exp=1/5/00001234", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
        checks++; if (bus.wb_stall !== 1'b0) begin failures++; $display("FAIL wb_only_stall got=%b exp=0", bus.wb_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu_deferred();
        bus.mdu_issue = 1; bus.mdu_issue_rd = 8; bus.id_rs = 8;
        tick();
        bus.mdu_issue = 0;
        // cycle 1: result arrives, WB wins
        bus.mdu_valid = 1; bus.mdu_rd = 8; bus.mdu_data = 32'hAAAA0008;
        bus.wb_valid = 1; bus.wb_rd = 9; bus.wb_data = 32'h99;
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3} !== {1'b1, 5'd9}) begin failures++; $display("FAIL defer_c1_grant got=%b/%0d exp=1/9", bus.rf_wr, bus.rf_a3); end
        checks++; if (bus.id_hazard !== 1'b1) begin failures++; $display("FAIL defer_c1_hazard got=%b exp=1", bus.id_hazard); end
        tick();
        // cycle 2: buffered, WB still wins
        bus.mdu_valid = 0; bus.wb_rd = 10; bus.wb_data = 32'h10;
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.wb_stall} !== {1'b1, 5'd10, 1'b0}) begin failures++; $display("FAIL defer_c2_grant got=%b/%0d/%b exp=1/10/0", bus.rf_wr, bus.rf_a3, bus.wb_stall); end
        checks++; if (bus.id_hazard !== 1'b1) begin failures++; $display("FAIL defer_c2_hazard got=%b exp=1", bus.id_hazard); end
        tick();
        // cycle 3: MDU writes
        bus.wb_valid = 0;
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd8, 32'hAAAA0008}) begin failures++; $display("FAIL defer_c3_mdu_write got=%b/%0d/%h exp=1/8/aaaa0008", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
        checks++; if (bus.id_hazard !== 1'b1) begin failures++; $display("FAIL defer_c3_hazard got=%b exp=1", bus.id_hazard); end
        tick();
        #1;
        checks++; if (bus.id_hazard !== 1'b0) begin failures++; $display("FAIL defer_c4_hazard got=%b exp=0", bus.id_hazard); end
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL defer_c4_idle got=%b exp=0", bus.rf_wr); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        bus.mdu_valid = 1; bus.mdu_rd = 12; bus.mdu_data = 32'hC0DE000C;
        bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h1;
        #1;
        checks++; if (bus.rf_a3 !== 5'd1) begin failures++; $display("FAIL starve_push_cycle got=%0d exp=1", bus.rf_a3); end
        tick();
        bus.mdu_valid = 0;
        for (int i = 0; i < 5; i++) begin
            bus.wb_rd = 5'(i + 2); bus.wb_data = 32'h100 + 32'(i);
            #1;
            if (i < 4) begin
                checks++; if ({bus.rf_a3, bus.wb_stall} !== {5'(i + 2), 1'b0}) begin failures++; $display("FAIL starve_lose_%0d got=%0d/%b exp=%0d/0", i, bus.rf_a3, bus.wb_stall, i + 2); end
            end else begin
                checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd, bus.wb_stall} !== {1'b1, 5'd12, 32'hC0DE000C, 1'b1}) begin failures++; $display("FAIL starve_forced got=%b/%0d/%h/%b exp=1/12/c0de000c/1", bus.rf_wr, bus.rf_a3, bus.rf_wd, bus.wb_stall); end
            end
            tick();
        end
        // held WB request from the stalled cycle
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd, bus.wb_stall} !== {1'b1, 5'd6, 32'h104, 1'b0}) begin failures++; $display("FAIL starve_held_wb got=%b/%0d/%h/%b exp=1/6/00000104/0", bus.rf_wr, bus.rf_a3, bus.rf_wd, bus.wb_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h1;
        bus.mdu_valid = 1; bus.mdu_rd = 20; bus.mdu_data = 32'h20;
        #1;
        checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL full_c1_ready got=%b exp=1", bus.mdu_ready); end
        tick();
        bus.mdu_rd = 21; bus.mdu_data = 32'h21; bus.wb_rd = 2;
        #1;
        checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL full_c2_ready got=%b exp=1", bus.mdu_ready); end
        tick();
        bus.mdu_rd = 22; bus.mdu_data = 32'h22;
        for (int c = 3; c <= 6; c++) begin
            bus.wb_rd = 5'(c);
            #1;
            checks++; if (bus.mdu_ready !== 1'b0) begin failures++; $display("FAIL full_c%0d_ready got=%b exp=0", c, bus.mdu_ready); end
            if (c == 6) begin
                checks++; if ({bus.rf_a3, bus.wb_stall} !== {5'd20, 1'b1}) begin failures++; $display("FAIL full_forced_pop got=%0d/%b exp=20/1", bus.rf_a3, bus.wb_stall); end
            end
            tick();
        end
        #1;
        checks++; if ({bus.mdu_ready, bus.rf_a3} !== {1'b1, 5'd6}) begin failures++; $display("FAIL full_c7_accept got=%b/%0d exp=1/6", bus.mdu_ready, bus.rf_a3); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd21, 32'h21}) begin failures++; $display("FAIL full_drain_21 got=%b/%0d/%h exp=1/21/00000021", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
        tick();
        #1;
        checks++; if ({bus.rf_wr, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd22, 32'h22}) begin failures++; $display("FAIL full_drain_22 got=%b/%0d/%h exp=1/22/00000022", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
        tick();
        #1;
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", bus.rf_wr); end
    endtask

    task automatic test_rd0();
        bus.mdu_issue = 1; bus.mdu_issue_rd = 3;
        tick();
        bus.mdu_issue = 1; bus.mdu_issue_rd = 0;
        bus.mdu_valid = 1; bus.mdu_rd = 0; bus.mdu_data = 32'hBAD0;
        bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hDEAD;
        #1;
        checks++; if ({bus.rf_wr, bus.mdu_ready, bus.wb_stall} !== 3'b010) begin failures++; $display("FAIL rd0_wb_write got=%b/%b/%b exp=0/1/0", bus.rf_wr, bus.mdu_ready, bus.wb_stall); end
        tick();
        idle_inputs();
        bus.id_rt = 3;
        #1;
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL rd0_mdu_discarded got=%b exp=0", bus.rf_wr); end
        checks++; if (bus.id_hazard !== 1'b1) begin failures++; $display("FAIL rd0_sb3_kept got=%b exp=1", bus.id_hazard); end
        bus.id_rt = 0;
        #1;
        checks++; if (bus.id_hazard !== 1'b0) begin failures++; $display("FAIL rd0_hazard_r0 got=%b exp=0", bus.id_hazard); end
        tick();
        #1;
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL rd0_still_idle got=%b exp=0", bus.rf_wr); end
    endtask

    task automatic test_async_reset();
        bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h1;
        bus.mdu_valid = 1; bus.mdu_rd = 14; bus.mdu_data = 32'h14;
        tick();
        bus.mdu_rd = 15; bus.mdu_data = 32'h15;
        tick();
        bus.mdu_valid = 0; bus.id_rs = 3;
        #1;
        checks++; if ({bus.mdu_ready, bus.id_hazard} !== 2'b01) begin failures++; $display("FAIL areset_pre got=%b/%b exp=0/1", bus.mdu_ready, bus.id_hazard); end
        #2;
        rst = 1'b1; bus.wb_valid = 0;
        #1;
        checks++; if ({bus.mdu_ready, bus.id_hazard, bus.rf_wr} !== 3'b100) begin failures++; $display("FAIL areset_immediate got=%b/%b/%b exp=1/0/0", bus.mdu_ready, bus.id_hazard, bus.rf_wr); end
        tick();
        rst = 1'b0;
        tick();
        #1;
        checks++; if ({bus.rf_wr, bus.mdu_ready, bus.id_hazard} !== 3'b010) begin failures++; $display("FAIL areset_dropped got=%b/%b/%b exp=0/1/0", bus.rf_wr, bus.mdu_ready, bus.id_hazard); end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_wb_only();
        test_mdu_deferred();
        test_starvation();
        test_full();
        test_rd0();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
